// File: rtl/stack_sequencer.sv
// stack_sequencer: runs 1-3 byte stack push/pull bus cycles and owns the stack pointer
module stack_sequencer #(
  parameter int DBW = 8,
  parameter int ABW = 16,
  parameter logic [7:0] STACK_PAGE = 8'h01,
  parameter logic [DBW-1:0] SP_RESET = 8'hFF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [1:0]     req_op,
  input  logic [1:0]     req_cnt,
  input  logic [23:0]    req_data,
  input  logic [DBW-1:0] sp_load,
  output logic           mem_cyc,
  output logic           mem_we,
  output logic [ABW-1:0] mem_adr,
  output logic [7:0]     mem_dat_o,
  input  logic [7:0]     mem_dat_i,
  input  logic           mem_ack,
  output logic           rsp_valid,
  output logic [23:0]    rsp_data,
  output logic [DBW-1:0] sp,
  output logic           wrap
);
  typedef enum logic [1:0] {IDLE, PUSH, PULL, DONE} state_t;
  state_t state, state_nx;
  logic [1:0] left, cnt_r, wr_idx, rd_idx;
  logic [23:0] data_r;
  logic [DBW-1:0] sp_inc, sp_dec;
  logic accept, step;
  assign sp_inc = sp + DBW'(1);
  assign sp_dec = sp - DBW'(1);
  assign wr_idx = left - 2'd1;
  assign rd_idx = cnt_r - left;
  assign accept = req_valid & req_ready;
  assign step = mem_cyc & mem_ack;
  // state register; reset aborts any bus cycle in flight
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // next state and bus/handshake outputs decoded from the current state
  always_comb begin
    state_nx = state;
    req_ready = 1'b0;
    mem_cyc = 1'b0;
    mem_we = 1'b0;
    mem_adr = '0;
    mem_dat_o = 8'h00;
    rsp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid)
          state_nx = (req_cnt == 2'd0) ? DONE : (req_op == 2'd1) ? PULL : (req_op == 2'd2) ? PUSH : DONE;
      end
      PUSH: begin
        mem_cyc = 1'b1;
        mem_we = 1'b1;
        mem_adr = ABW'({STACK_PAGE, sp});
        mem_dat_o = (wr_idx == 2'd2) ? data_r[23:16] : (wr_idx == 2'd1) ? data_r[15:8] : data_r[7:0];
        if (mem_ack && left == 2'd1) state_nx = DONE;
      end
      PULL: begin
        mem_cyc = 1'b1;
        mem_adr = ABW'({STACK_PAGE, sp_inc});
        if (mem_ack && left == 2'd1) state_nx = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
  // datapath: latch request, move sp per acked byte, gather pulled bytes, flag wraps
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sp <= SP_RESET;
      left <= 2'd0;
      cnt_r <= 2'd0;
      data_r <= 24'h0;
      rsp_data <= 24'h0;
      wrap <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (accept) begin
        left <= req_cnt;
        cnt_r <= req_cnt;
        data_r <= req_data;
        rsp_data <= 24'h0;
        if (req_op == 2'd3) sp <= sp_load;
      end else if (step) begin
        left <= left - 2'd1;
        sp <= mem_we ? sp_dec : sp_inc;
        wrap <= mem_we ? (sp == '0) : (sp == '1);
        if (!mem_we)
          rsp_data <= (rd_idx == 2'd2) ? {mem_dat_i, rsp_data[15:0]} :
                      (rd_idx == 2'd1) ? {rsp_data[23:16], mem_dat_i, rsp_data[7:0]} :
                                         {rsp_data[23:8], mem_dat_i};
      end
    end
endmodule
